// File: rtl/sram_slv_pkg.sv
// rtl/sram_slv_pkg.sv - shared AXI widths, response/burst codes and FSM state for the SRAM slave
package sram_slv_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R_REQ,
        ST_R_CAP,
        ST_R_DATA,
        ST_W_DATA,
        ST_W_RESP
    } state_e;

    // SRAM bit-write-enable is active-low, one byte lane per strobe bit
    function automatic logic [AXI_DATA_W-1:0] strb_to_bweb(input logic [AXI_STRB_W-1:0] strb);
        logic [AXI_DATA_W-1:0] m;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            m[i*8 +: 8] = {8{~strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_axi_slave_if.sv
// rtl/sram_axi_slave_if.sv - AXI channel bundle between the slave-side CDC FIFOs and the SRAM slave
interface sram_axi_slave_if;
    import sram_slv_pkg::*;

    logic [AXI_ID_W-1:0]   AWID;
    logic [AXI_ADDR_W-1:0] AWADDR;
    logic [AXI_LEN_W-1:0]  AWLEN;
    logic [AXI_SIZE_W-1:0] AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DATA_W-1:0] WDATA;
    logic [AXI_STRB_W-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_ID_W-1:0]   ARID;
    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [AXI_LEN_W-1:0]  ARLEN;
    logic [AXI_SIZE_W-1:0] ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [AXI_ID_W-1:0]   RID;
    logic [AXI_DATA_W-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    logic [AXI_ID_W-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/sram_slv_addr_gen.sv
// rtl/sram_slv_addr_gen.sv - burst word address, beat counter and last-beat flag
module sram_slv_addr_gen
    import sram_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [AXI_LEN_W-1:0]  load_len,
    input  logic [1:0]            load_burst,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [1:0]            burst_q, burst_d;

    // WRAP is sequenced like INCR; the word address rolls over at the top of the macro
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        burst_d = burst_q;
        if (load) begin
            addr_d  = load_addr;
            cnt_d   = '0;
            len_d   = load_len;
            burst_d = load_burst;
        end else if (advance) begin
            cnt_d = cnt_q + 1'b1;
            if (burst_q != BURST_FIXED) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == len_q);

endmodule

// File: rtl/sram_axi_slave.sv
// rtl/sram_axi_slave.sv - AXI burst slave onto a single-port synchronous SRAM macro
// SRAM_SLV_ERR_EN: out-of-range start addresses answer SLVERR without touching the SRAM.
module sram_axi_slave
    import sram_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_axi_slave_if.slave       axi,
    output logic                  CEB,
    output logic                  WEB,
    output logic [AXI_DATA_W-1:0] BWEB,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [AXI_DATA_W-1:0] DI,
    input  logic [AXI_DATA_W-1:0] DO
);

    state_e                state_q, state_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic                  err_q, err_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;

    logic                  load, advance, last;
    logic [ADDR_WIDTH-1:0] addr, load_addr;
    logic [AXI_LEN_W-1:0]  load_len;
    logic [1:0]            load_burst;
    logic                  ar_oor, aw_oor;

`ifdef SRAM_SLV_ERR_EN
    assign ar_oor = |axi.ARADDR[AXI_ADDR_W-1:ADDR_WIDTH+2];
    assign aw_oor = |axi.AWADDR[AXI_ADDR_W-1:ADDR_WIDTH+2];
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    // Read wins a simultaneous AR/AW request, so the load mux follows ARVALID
    assign load_addr  = axi.ARVALID ? axi.ARADDR[ADDR_WIDTH+1:2] : axi.AWADDR[ADDR_WIDTH+1:2];
    assign load_len   = axi.ARVALID ? axi.ARLEN   : axi.AWLEN;
    assign load_burst = axi.ARVALID ? axi.ARBURST : axi.AWBURST;

    logic unused_sig;
    assign unused_sig = ^{axi.ARSIZE, axi.AWSIZE, axi.ARADDR, axi.AWADDR};

    sram_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_addr  (load_addr),
        .load_len   (load_len),
        .load_burst (load_burst),
        .advance    (advance),
        .addr       (addr),
        .last       (last)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        load        = 1'b0;
        advance     = 1'b0;
        axi.ARREADY = 1'b0;
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.RVALID  = 1'b0;
        axi.BVALID  = 1'b0;
        CEB         = 1'b1;
        WEB         = 1'b1;
        BWEB        = '1;
        case (state_q)
            ST_IDLE: begin
                axi.ARREADY = 1'b1;
                axi.AWREADY = ~axi.ARVALID;
                if (axi.ARVALID) begin
                    load    = 1'b1;
                    id_d    = axi.ARID;
                    err_d   = ar_oor;
                    state_d = ST_R_REQ;
                end else if (axi.AWVALID) begin
                    load    = 1'b1;
                    id_d    = axi.AWID;
                    err_d   = aw_oor;
                    state_d = ST_W_DATA;
                end
            end
            ST_R_REQ: begin
                CEB     = err_q;
                state_d = ST_R_CAP;
            end
            ST_R_CAP: begin
                rdata_d = err_q ? '0 : DO;
                state_d = ST_R_DATA;
            end
            ST_R_DATA: begin
                axi.RVALID = 1'b1;
                if (axi.RREADY) begin
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_R_REQ;
                    end
                end
            end
            ST_W_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    CEB     = err_q;
                    WEB     = err_q;
                    BWEB    = err_q ? '1 : strb_to_bweb(axi.WSTRB);
                    advance = 1'b1;
                    if (axi.WLAST) begin
                        state_d = ST_W_RESP;
                    end
                end
            end
            ST_W_RESP: begin
                axi.BVALID = 1'b1;
                if (axi.BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign axi.RID   = id_q;
    assign axi.RDATA = rdata_q;
    assign axi.RRESP = (state_q == ST_R_DATA && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.RLAST = (state_q == ST_R_DATA) && last;
    assign axi.BID   = id_q;
    assign axi.BRESP = (state_q == ST_W_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign A         = addr;
    assign DI        = axi.WDATA;

endmodule

// File: doc/sram_axi_slave.md
# sram_axi_slave

AXI slave endpoint that sits directly downstream of the slave-side clock-domain-crossing FIFOs, in the slave clock domain, and turns AXI bursts into accesses on a single-port synchronous SRAM macro. It accepts one transaction at a time (read or write), sequences INCR/FIXED bursts beat by beat, and returns R/B responses with full ready/valid backpressure. All AXI signal widths come from the shared AXI definitions (IDS, ADDR, DATA, LEN, SIZE, STRB bits).

## Interface
- ADDR_WIDTH, 14: SRAM word-address bits; 2^ADDR_WIDTH 32-bit words.
- clk  in  1  slave-domain clock; single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  AXI widths  write address; AWREADY out 1.
- WDATA/WSTRB/WLAST/WVALID  in  AXI widths  write data; WREADY out 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  AXI widths  read address; ARREADY out 1.
- RID/RDATA/RRESP/RLAST/RVALID  out  AXI widths  read data; RREADY in 1.
- BID/BRESP/BVALID  out  AXI widths  write response; BREADY in 1.
- CEB  out  1  SRAM chip enable, active-low.
- WEB  out  1  SRAM write enable, active-low.
- BWEB  out  32  SRAM bit write enable, active-low; byte i bits = ~WSTRB[i].
- A  out  ADDR_WIDTH  SRAM word address.
- DI  out  32  SRAM write data (= WDATA).
- DO  in  32  SRAM read data, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, R_REQ, R_CAP, R_DATA, W_DATA, W_RESP. Reset → IDLE.
- IDLE: ARREADY=1; AWREADY = ~ARVALID (read wins on simultaneous valid). Handshake latches ID, word address ADDR[ADDR_WIDTH+1:2], LEN, BURST; beat counter cleared.
- Read: R_REQ drives CEB=0, WEB=1, A=addr. R_CAP registers DO into rdata_q. R_DATA: RVALID=1, RDATA=rdata_q, RID=latched ID, RRESP=OKAY, RLAST=(cnt==LEN). On R handshake: if RLAST → IDLE, else cnt+1, addr advance, → R_REQ.
- Write: W_DATA: WREADY=1; each W handshake strobes SRAM same cycle (CEB=0, WEB=0, BWEB from WSTRB, DI=WDATA, A=addr), then cnt+1, addr advance. Burst ends on WLAST handshake (beat count not checked) → W_RESP.
- W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY until BREADY; then IDLE.
- Address advance: INCR and WRAP add 1 word; FIXED holds. Word address wraps modulo 2^ADDR_WIDTH. AWSIZE/ARSIZE ignored (32-bit beats).
- Outside R_REQ and W handshake: CEB=1, WEB=1, BWEB all 1.
- rst mid-burst: FSM → IDLE, outstanding burst dropped, no response issued.

## Timing
- Reset values: RVALID, BVALID, WREADY = 0; RDATA, RID, RRESP, RLAST, BID, BRESP = 0; CEB=WEB=1, BWEB all 1; ARREADY=1, AWREADY=1 after reset (IDLE).
- AR handshake cycle n → R_REQ n+1, R_CAP n+2, RVALID high from n+3. Each further beat: R handshake cycle m → RVALID again at m+3.
- AW handshake cycle n → WREADY high from n+1; one beat per cycle at full WVALID.
- WLAST handshake cycle m → BVALID high from m+1.
- RVALID/BVALID with payload held stable until handshake; no valid deasserts without handshake.

## Configuration
- SRAM_SLV_ERR_EN defined: a transaction whose start ADDR[31:ADDR_WIDTH+2] is nonzero is out-of-range; reads return RDATA=0, RRESP=SLVERR (2'b10) on every beat with no SRAM strobe; writes consume all W beats without SRAM strobe, BRESP=SLVERR.
- Undefined: upper address bits ignored (aliasing), all responses OKAY.

## Structure
- Package sram_slv_pkg: state enum, RESP_OKAY=2'b00/RESP_SLVERR=2'b10, BURST_FIXED/INCR/WRAP codes.
- One sub-module: sram_slv_addr_gen (latched address, beat counter, next-address/last-beat logic).

## Test plan
- AR ID=3, ADDR=0x10, LEN=0, preloaded word 4=0xDEADBEEF -> RVALID at handshake+3, RDATA=0xDEADBEEF, RID=3, RLAST=1, RRESP=0.
- AW ID=5, ADDR=0x0, LEN=3 INCR, WDATA 1..4, WSTRB=0xF -> words 0..3 = 1..4, BVALID one cycle after WLAST, BID=5, BRESP=0.
- Write WSTRB=0x5 data 0xAABBCCDD over 0x11223344 -> word reads 0x11BB33DD.
- Read LEN=3 starting at last word 2^ADDR_WIDTH-1 with RREADY low 5 cycles per beat -> address wraps to 0, RDATA stable while stalled, RLAST on beat 4 only.
- ARVALID and AWVALID same cycle in IDLE -> ARREADY=1, AWREADY=0; write accepted after read completes.
- With SRAM_SLV_ERR_EN, AR ADDR=0x0010_0000 -> RRESP=2'b10, RDATA=0, CEB stays 1; rst asserted mid write burst -> IDLE next cycle, BVALID never asserted.
